// File: rtl/maf_dot_sequencer_pkg.sv
// Shared types for the MAF dot-product sequencer.
// Exception tags, the zero word and the FSM state encoding.
package maf_dot_sequencer_pkg;

  localparam logic [1:0] TAG_ZERO   = 2'b00;
  localparam logic [1:0] TAG_NORMAL = 2'b01;
  localparam logic [1:0] TAG_INF    = 2'b10;
  localparam logic [1:0] TAG_NAN    = 2'b11;

  localparam int WORD_BITS = 34;
  localparam logic [WORD_BITS-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/maf_dot_sequencer_if.sv
// Operand-in / result-out handshakes of the dot-product sequencer.
// master is the producer/consumer side, slave is the sequencer.
interface maf_dot_sequencer_if #(
  parameter int size = 34
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [size-1:0] a_i;
  logic [size-1:0] b_i;
  logic [size-1:0] result_o;
  logic            result_valid_o;
  logic            result_ready_i;

  modport master (
    output in_valid_i, a_i, b_i, result_ready_i,
    input  in_ready_o, result_o, result_valid_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, result_ready_i,
    output in_ready_o, result_o, result_valid_o
  );
endinterface

// File: rtl/maf_dot_sequencer.sv
// Feeds (a, b, acc) into an external MAF one term at a time and
// accumulates sum(a_k*b_k); waits maf_latency extra cycles per term.
module maf_dot_sequencer
  import maf_dot_sequencer_pkg::*;
#(
  parameter int size_exponent        = 8,
  parameter int size_mantissa        = 24,
  parameter int size_exception_field = 2,
  parameter int size = size_exponent + size_mantissa
                     + size_exception_field,
  parameter int size_len             = 8,
  parameter int maf_latency          = 0,
  parameter int size_wait            = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [size_len-1:0] len_i,
  maf_dot_sequencer_if.slave  io,
  output logic [size-1:0]     maf_a_o,
  output logic [size-1:0]     maf_b_o,
  output logic [size-1:0]     maf_c_o,
  output logic                maf_sub_o,
  input  logic [size-1:0]     maf_result_i,
  output logic                busy_o
);

  localparam logic [size-1:0] ZERO = size'(ZERO_WORD);
  localparam logic [size_wait-1:0] WAIT_LOAD =
    size_wait'(maf_latency);
  localparam logic [size_len-1:0] ONE = size_len'(1);

  state_e              state;
  state_e              state_n;
  logic [size_len-1:0] remaining;
  logic [size_wait-1:0] wait_q;
  logic [size-1:0]     acc;

  logic wait_done;
  logic last_term;

  assign wait_done = (wait_q == '0);
  assign last_term = (remaining == ONE);
  assign maf_sub_o = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start_i)
          state_n = (len_i == '0) ? S_DONE : S_FETCH;
      S_FETCH:
        if (io.in_valid_i) state_n = S_WAIT;
      S_WAIT:
        if (wait_done)
          state_n = last_term ? S_DONE : S_FETCH;
      S_DONE:
        if (io.result_ready_i) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    io.in_ready_o     = 1'b0;
    io.result_valid_o = 1'b0;
    busy_o            = 1'b1;
    unique case (state)
      S_IDLE:  busy_o            = 1'b0;
      S_FETCH: io.in_ready_o     = 1'b1;
      S_DONE:  io.result_valid_o = 1'b1;
      default: ;
    endcase
  end

  // One MAF op in flight: operands are issued in FETCH, result
  // is taken only once the wait counter has drained.
  always_ff @(posedge clk) begin
    if (!rst) begin
      remaining   <= '0;
      wait_q      <= '0;
      acc         <= ZERO;
      maf_a_o     <= ZERO;
      maf_b_o     <= ZERO;
      maf_c_o     <= ZERO;
      io.result_o <= ZERO;
    end else begin
      unique case (state)
        S_IDLE:
          if (start_i) begin
            remaining <= len_i;
            acc       <= ZERO;
            if (len_i == '0) io.result_o <= ZERO;
          end
        S_FETCH:
          if (io.in_valid_i) begin
            maf_a_o <= io.a_i;
            maf_b_o <= io.b_i;
            maf_c_o <= acc;
            wait_q  <= WAIT_LOAD;
          end
        S_WAIT:
          if (wait_done) begin
            acc       <= maf_result_i;
            remaining <= remaining - ONE;
            if (last_term) io.result_o <= maf_result_i;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maf_dot_sequencer.sv
// Bench: two sequencers (latency 0 and 3) with a float MAF model,
// directed runs plus randomized runs against a fold reference.
module tb_maf_dot_sequencer;
  import maf_dot_sequencer_pkg::*;

  localparam int SZ = 34;
  typedef logic [SZ-1:0] word_t;

  localparam word_t W_1   = {2'b01, 32'h3F80_0000};
  localparam word_t W_2   = {2'b01, 32'h4000_0000};
  localparam word_t W_3   = {2'b01, 32'h4040_0000};
  localparam word_t W_4   = {2'b01, 32'h4080_0000};
  localparam word_t W_M4  = {2'b01, 32'hC080_0000};
  localparam word_t W_H   = {2'b01, 32'h3F00_0000};
  localparam word_t W_9   = {2'b01, 32'h4110_0000};
  localparam word_t W_15  = {2'b01, 32'h4170_0000};
  localparam word_t W_255 = {2'b01, 32'h437F_0000};
  localparam word_t W_NAN = {2'b11, 32'h7FC0_0000};
  localparam word_t W_INF = {2'b10, 32'h7F80_0000};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] len = '0;
  logic       in_valid = 1'b0;
  logic       rready = 1'b0;
  word_t      a = '0;
  word_t      b = '0;

  int n_cmp = 0;
  int n_bad = 0;

  word_t pa[$];
  word_t pb[$];

  function automatic real to_real(word_t w);
    real v;
    int  e;
    if (w[33:32] == TAG_ZERO) return 0.0;
    v = real'({1'b1, w[22:0]});
    e = int'(w[30:23]) - 150;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return w[31] ? -v : v;
  endfunction

  function automatic word_t from_real(real r);
    real        m;
    int         e;
    logic       s;
    logic [22:0] f;
    if (r == 0.0) return '0;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'($rtoi((m - 1.0) * 8388608.0 + 0.5));
    return {TAG_NORMAL, s, 8'(e + 127), f};
  endfunction

  function automatic word_t maf_fn(word_t x, word_t y, word_t z);
    if (x[33:32] == TAG_NAN || y[33:32] == TAG_NAN ||
        z[33:32] == TAG_NAN)
      return W_NAN;
    if (x[33:32] == TAG_INF || y[33:32] == TAG_INF ||
        z[33:32] == TAG_INF)
      return W_INF;
    return from_real(to_real(x) * to_real(y) + to_real(z));
  endfunction

  maf_dot_sequencer_if #(.size(SZ)) if0 ();
  maf_dot_sequencer_if #(.size(SZ)) if1 ();

  assign if0.in_valid_i     = in_valid;
  assign if0.a_i            = a;
  assign if0.b_i            = b;
  assign if0.result_ready_i = rready;
  assign if1.in_valid_i     = in_valid;
  assign if1.a_i            = a;
  assign if1.b_i            = b;
  assign if1.result_ready_i = rready;

  word_t ma0, mb0, mc0, mr0;
  word_t ma1, mb1, mc1, mr1;
  logic  sub0, sub1, busy0, busy1;

  maf_dot_sequencer #(.maf_latency(0), .size_wait(3)) dut0 (
    .clk(clk), .rst(rst), .start_i(start & ~sel), .len_i(len),
    .io(if0.slave),
    .maf_a_o(ma0), .maf_b_o(mb0), .maf_c_o(mc0),
    .maf_sub_o(sub0), .maf_result_i(mr0), .busy_o(busy0)
  );

  maf_dot_sequencer #(.maf_latency(3), .size_wait(3)) dut1 (
    .clk(clk), .rst(rst), .start_i(start & sel), .len_i(len),
    .io(if1.slave),
    .maf_a_o(ma1), .maf_b_o(mb1), .maf_c_o(mc1),
    .maf_sub_o(sub1), .maf_result_i(mr1), .busy_o(busy1)
  );

  // MAF models: combinational for dut0, three-stage pipe for dut1
  assign mr0 = maf_fn(ma0, mb0, mc0);
  word_t p0 = '0, p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p0 <= maf_fn(ma1, mb1, mc1);
    p1 <= p0;
    p2 <= p1;
  end
  assign mr1 = p2;

  logic  rv, ir, busy, sub;
  word_t res, ma, mb, mc;
  assign rv   = sel ? if1.result_valid_o : if0.result_valid_o;
  assign ir   = sel ? if1.in_ready_o : if0.in_ready_o;
  assign res  = sel ? if1.result_o : if0.result_o;
  assign busy = sel ? busy1 : busy0;
  assign sub  = sel ? sub1 : sub0;
  assign ma   = sel ? ma1 : ma0;
  assign mb   = sel ? mb1 : mb0;
  assign mc   = sel ? mc1 : mc0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_dot(input bit s, input int gap, input int stall,
                         input bit poke, output word_t got);
    int    n, cyc, k, gc, rdy_cnt, last_rdy, lat;
    bit    acc_now, poked, timed;
    word_t exp;
    n = pa.size();
    lat = s ? 3 : 0;
    timed = (gap == 0);
    exp = '0;
    foreach (pa[i]) exp = maf_fn(pa[i], pb[i], exp);
    cyc = 0; k = 0; gc = gap; rdy_cnt = 0; last_rdy = -1;
    poked = 0;
    sel = s;
    @(negedge clk);
    start = 1'b1;
    len = 8'(n);
    if (n > 0 && gap == 0) begin
      a = pa[0]; b = pb[0]; in_valid = 1'b1;
    end
    while (!rv && cyc < 4000) begin
      acc_now = in_valid && ir;
      if (ir) begin
        rdy_cnt++;
        if (timed && last_rdy >= 0)
          chk("rdy_spacing", 64'(cyc - last_rdy), 64'(lat + 2));
        last_rdy = cyc;
      end
      if (poke && ir && !poked) begin
        start = 1'b1; len = 8'd1; poked = 1;
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (acc_now) begin
        k++; in_valid = 1'b0; gc = gap;
      end
      if (!in_valid && k < n) begin
        if (gc == 0) begin
          a = pa[k]; b = pb[k]; in_valid = 1'b1;
        end else gc--;
      end
    end
    in_valid = 1'b0;
    chk("done_seen", 64'(rv), 64'd1);
    if (timed) begin
      chk("latency", 64'(cyc), 64'(1 + n * (lat + 2)));
      chk("rdy_count", 64'(rdy_cnt), 64'(n));
    end
    chk("result", 64'(res), 64'(exp));
    got = res;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_result", 64'(res), 64'(exp));
      chk("stall_valid", 64'(rv), 64'd1);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("busy_after", 64'(busy), 64'd0);
    chk("valid_after", 64'(rv), 64'd0);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_ready"}, 64'(ir), 64'd0);
    chk({tag, "_valid"}, 64'(rv), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sub"}, 64'(sub), 64'd0);
    chk({tag, "_ma"}, 64'(ma), 64'd0);
    chk({tag, "_mb"}, 64'(mb), 64'd0);
    chk({tag, "_mc"}, 64'(mc), 64'd0);
    chk({tag, "_res"}, 64'(res), 64'd0);
  endtask

  initial begin
    word_t got;
    int    n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0; reset_checks("rst0");
    sel = 1'b1; reset_checks("rst1");
    rst = 1'b1;

    pa = '{W_1, W_3, W_H}; pb = '{W_2, W_4, W_2};
    run_dot(0, 0, 0, 0, got);
    chk("dot15", 64'(got), 64'(W_15));

    pa = {}; pb = {};
    run_dot(0, 0, 0, 0, got);
    chk("n0_zero", 64'(got), 64'd0);
    run_dot(1, 0, 1, 0, got);
    chk("n0_zero_l3", 64'(got), 64'd0);

    pa = '{W_2, W_1}; pb = '{W_2, W_M4};
    run_dot(1, 0, 0, 0, got);
    chk("cancel_zero", 64'(got), 64'd0);

    pa = '{W_1, W_3, W_H}; pb = '{W_2, W_4, W_2};
    run_dot(0, 4, 6, 0, got);
    chk("gapped15", 64'(got), 64'(W_15));
    run_dot(1, 4, 6, 0, got);
    chk("gapped15_l3", 64'(got), 64'(W_15));

    pa = '{W_1, W_NAN, W_2}; pb = '{W_2, W_3, W_2};
    run_dot(0, 0, 0, 1, got);
    chk("nan_tag", 64'(got[33:32]), 64'(TAG_NAN));

    pa = {}; pb = {};
    for (int i = 0; i < 255; i++) begin
      pa.push_back(W_1); pb.push_back(W_1);
    end
    run_dot(0, 0, 0, 0, got);
    chk("n255", 64'(got), 64'(W_255));

    // reset in the middle of the second term's wait
    sel = 1'b1;
    @(negedge clk);
    start = 1'b1; len = 8'd4;
    a = W_2; b = W_2; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_ready", 64'(ir), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    rst = 1'b1;
    pa = '{W_3}; pb = '{W_3};
    run_dot(1, 0, 0, 0, got);
    chk("after_rst9", 64'(got), 64'(W_9));

    for (int t = 0; t < 24; t++) begin
      pa = {}; pb = {};
      n = 1 + int'($urandom % 6);
      for (int i = 0; i < n; i++) begin
        word_t x, y;
        x = from_real(real'(int'($urandom % 17) - 8));
        y = from_real(real'(int'($urandom % 17) - 8));
        if ($urandom % 16 == 0) x = W_NAN;
        if ($urandom % 16 == 0) y = W_INF;
        pa.push_back(x); pb.push_back(y);
      end
      run_dot(1'($urandom % 2), int'($urandom % 3),
              int'($urandom % 3), 1'($urandom % 2), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maf_dot_sequencer.md
# maf_dot_sequencer

Sequencing stage directly upstream of the multiply-accumulate unit. Accepts a stream of (a, b) operand pairs over a valid/ready handshake and drives the MAF's a/b/c inputs, with c fed back from the MAF result. Produces the N-term dot product sum(a_k*b_k) in the team's exception-tagged float format. Handles an optional MAF pipeline latency with a wait counter, so one MAF instance serves both combinational and pipelined builds.

## Interface
Parameters:
- size_exponent, 8, exponent bits
- size_mantissa, 24, mantissa bits including hidden bit; 23 are stored
- size_exception_field, 2, exception tag: 00 zero, 01 normal, 10 infinity, 11 NaN
- size = size_exponent+size_mantissa+size_exception_field, 34, word width
- size_len, 8, width of the term count
- maf_latency, 0, MAF cycles from operands to result; 0 means combinational
- size_wait, 3, counter width; must satisfy 2^size_wait > maf_latency

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- start_i  in  1  begin a new dot product; sampled only in IDLE
- len_i  in  size_len  number of terms N; sampled with start_i
- in_valid_i  in  1  a_i/b_i hold a valid pair
- in_ready_o  out  1  sequencer accepts a pair this cycle
- a_i, b_i  in  size  operand pair
- maf_a_o, maf_b_o, maf_c_o  out  size  registered MAF operands
- maf_sub_o  out  1  tied 0 (accumulate)
- maf_result_i  in  size  MAF result
- result_o  out  size  final sum
- result_valid_o  out  1  result_o valid
- result_ready_i  in  1  consumer takes the result
- busy_o  out  1  high in any state except IDLE

## Operation
- Word layout: {tag[size-1:size-2], sign, exponent, stored mantissa}. The zero word has tag 00 and all other bits 0.
- States:
  - IDLE: on start_i, latch remaining = len_i and acc = zero word. Go to FETCH if len_i != 0. Go to DONE with result = zero word if len_i == 0.
  - FETCH: in_ready_o = 1. On in_valid_i, register maf_a_o = a_i, maf_b_o = b_i, maf_c_o = acc. Load wait = maf_latency, then go to WAIT.
  - WAIT: decrement wait each cycle. When wait == 0, capture acc = maf_result_i and decrement remaining. If remaining is now 0, go to DONE with result_o = acc; otherwise go to FETCH.
  - DONE: result_valid_o = 1. Go to IDLE when result_ready_i is high.
- Ordering: exactly one MAF operation is outstanding at a time. Accumulation order is strictly k = 0..N-1.
- start_i outside IDLE is ignored; len_i is not re-sampled.
- Tags are not interpreted here. NaN/infinity propagation is the MAF's job, and the sequencer forwards whatever it returns.
- Hold rules:
  - maf_* outputs hold their last values between issues.
  - result_o holds its value from DONE entry until the next DONE entry.

## Timing
- Reset with rst = 0 at a clock edge:
  - State goes to IDLE.
  - in_ready_o = 0, result_valid_o = 0, busy_o = 0.
  - maf_a_o, maf_b_o, maf_c_o and result_o all become the zero word; maf_sub_o = 0.
  - Reset mid-operation discards the partial sum; no result is produced.
- in_ready_o is combinational from state: high only in FETCH.
- Per term: 1 FETCH cycle (if valid is already high) plus maf_latency+1 WAIT cycles.
- Total from start_i to result_valid_o: 1 + N*(maf_latency+2) cycles, assuming in_valid_i stays high. For N = 0 it is 1 cycle.
- Handshakes:
  - A pair is accepted on the edge where in_valid_i and in_ready_o are both high.
  - A result is consumed on the edge where result_valid_o and result_ready_i are both high.
  - start_i asserted on the cycle the DONE→IDLE handshake completes is ignored; start is seen only from IDLE on the next cycle.
- remaining counts down from len_i. N = 2^size_len-1 is legal, with no wrap.

## Structure
- Shared package: exception tag constants (zero, normal, infinity, NaN), the zero-word constant, and the state encoding (IDLE, FETCH, WAIT, DONE).
- Single module, no sub-modules. The MAF is instantiated beside it by the parent, not inside it.
- Optional top-level wrapper maf_dot_top instantiating this block plus the MAF, used by the bench.

## Test plan
- maf_latency=0, N=3, pairs (1.0,2.0), (3.0,4.0), (0.5,2.0) → result 15.0 after 7 cycles; busy_o falls after the result_ready_i handshake.
- N=0 start → result_valid_o high 1 cycle after start with the zero word; in_ready_o never asserts.
- maf_latency=3, N=2, (2.0,2.0), (1.0,−4.0) → result 0 with tag 00; in_ready_o pulses exactly twice, 5 cycles apart.
- in_valid_i gapped (low 4 cycles between pairs) and result_ready_i held low 6 cycles → same sum; result_o and result_valid_o stable throughout the stall.
- rst=0 in WAIT midway through an N=4 run → all outputs take their reset values next edge. A new N=1 run with (3.0,3.0) gives 9.0.
- NaN-tagged a in term 2 of N=3 → result tag 11; start_i pulsed during FETCH is ignored.
